// File: rtl/im_fetch_buf.sv
// im_fetch_buf: pipelined instruction memory for the fetch stage.
// A request handshake feeds a one-cycle synchronous read stage (s1), which
// drains into a two-entry response FIFO whose head drives resp_* and the
// decoded MIPS fields. Misaligned or out-of-range fetches return a zero word
// with resp_err set and never touch the array.
// Optional write port: define IM_WRITE_EN to add wr_en/wr_addr/wr_data.
module im_fetch_buf #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
  parameter string       INIT_FILE  = "code.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
`ifdef IM_WRITE_EN
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_pc,
  output logic [31:0] resp_instr,
  output logic        resp_err,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic [25:0] ins25
);

  localparam int          DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH) << 2;

  logic [31:0] mem [DEPTH];

  // Request decode: offset from the base, range/alignment error, word index
  logic [31:0]           req_off;
  logic                  req_err;
  logic [DEPTH_LOG2-1:0] req_idx;

  assign req_off = req_addr - BASE_ADDR;
  assign req_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_off} >= SPAN_BYTES);
  assign req_idx = req_off[DEPTH_LOG2+1:2];

`ifdef IM_WRITE_EN
  logic [31:0]           wr_off;
  logic                  wr_ok;
  logic [DEPTH_LOG2-1:0] wr_idx;

  assign wr_off = wr_addr - BASE_ADDR;
  assign wr_ok  = wr_en && (wr_addr[1:0] == 2'b00) && ({1'b0, wr_off} < SPAN_BYTES);
  assign wr_idx = wr_off[DEPTH_LOG2+1:2];
`endif

  // State
  logic        s1_v_q, s1_v_d;
  logic [31:0] s1_pc_q, s1_pc_d;
  logic        s1_err_q, s1_err_d;
  logic [31:0] rd_word_q;
  logic [31:0] s1_instr;

  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] ent_pc_q    [2];
  logic [31:0] ent_pc_d    [2];
  logic [31:0] ent_instr_q [2];
  logic [31:0] ent_instr_d [2];
  logic        ent_err_q   [2];
  logic        ent_err_d   [2];

  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        hold_err_q, hold_err_d;

  logic        push;
  logic        pop;
  logic        accept;
  logic [2:0]  occupancy;

  // Array port: optional write plus synchronous read; NBA gives read-before-write
  always_ff @(posedge clk) begin
`ifdef IM_WRITE_EN
    if (wr_ok) mem[wr_idx] <= wr_data;
`endif
    if (accept && !req_err) rd_word_q <= mem[req_idx];
  end

  assign s1_instr   = s1_err_q ? 32'h0000_0000 : rd_word_q;
  assign push       = s1_v_q;
  assign resp_valid = (count_q != 2'd0);
  assign pop        = resp_valid && resp_ready;
  assign occupancy  = 3'(count_q) + 3'(s1_v_q) - 3'(pop);
  assign req_ready  = !flush && (occupancy < 3'd2);
  assign accept     = req_valid && req_ready;

  // Head of the FIFO when non-empty, otherwise the last presented response
  assign resp_pc    = resp_valid ? ent_pc_q[rd_ptr_q]    : hold_pc_q;
  assign resp_instr = resp_valid ? ent_instr_q[rd_ptr_q] : hold_instr_q;
  assign resp_err   = resp_valid ? ent_err_q[rd_ptr_q]   : hold_err_q;

  assign op    = resp_instr[31:26];
  assign rs    = resp_instr[25:21];
  assign rt    = resp_instr[20:16];
  assign rd    = resp_instr[15:11];
  assign func  = resp_instr[5:0];
  assign imm   = resp_instr[15:0];
  assign ins25 = resp_instr[25:0];

  // Next-state: flush wins, otherwise accept into s1, push s1, pop head
  always_comb begin
    s1_v_d       = s1_v_q;
    s1_pc_d      = s1_pc_q;
    s1_err_d     = s1_err_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ent_pc_d     = ent_pc_q;
    ent_instr_d  = ent_instr_q;
    ent_err_d    = ent_err_q;
    hold_pc_d    = resp_pc;
    hold_instr_d = resp_instr;
    hold_err_d   = resp_err;

    if (flush) begin
      s1_v_d   = 1'b0;
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      s1_v_d = accept;
      if (accept) begin
        s1_pc_d  = req_addr;
        s1_err_d = req_err;
      end
      if (push) begin
        ent_pc_d[wr_ptr_q]    = s1_pc_q;
        ent_instr_d[wr_ptr_q] = s1_instr;
        ent_err_d[wr_ptr_q]   = s1_err_q;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  // Pipeline and FIFO registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q       <= 1'b0;
      s1_pc_q      <= '0;
      s1_err_q     <= 1'b0;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
      hold_err_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
        ent_err_q[i]   <= 1'b0;
      end
    end else begin
      s1_v_q       <= s1_v_d;
      s1_pc_q      <= s1_pc_d;
      s1_err_q     <= s1_err_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_err_q   <= hold_err_d;
      for (int i = 0; i < 2; i++) begin
        ent_pc_q[i]    <= ent_pc_d[i];
        ent_instr_q[i] <= ent_instr_d[i];
        ent_err_q[i]   <= ent_err_d[i];
      end
    end
  end

  // s1 must never push into a full FIFO unless the head leaves that cycle
  assert property (@(posedge clk) disable iff (!reset)
                   (s1_v_q && !flush) |-> ((count_q < 2'd2) || pop));

  assert property (@(posedge clk) disable iff (!reset) count_q != 2'd3);

endmodule

// File: tb/tb_im_fetch_buf.sv
// Testbench for im_fetch_buf: scoreboard of expected responses, pushed on
// each accepted request and popped on each resp_valid && resp_ready.
module tb_im_fetch_buf;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_pc;
  logic [31:0] resp_instr;
  logic        resp_err;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  func;
  logic [15:0] imm;
  logic [25:0] ins25;
`ifdef IM_WRITE_EN
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] model_mem [DEPTH];
  int          checks = 0;
  int          errors = 0;
  int          popCount = 0;
  int          acceptCount = 0;

  im_fetch_buf #(
    .DEPTH_LOG2(10),
    .BASE_ADDR (BASE),
    .INIT_FILE ("")
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
`ifdef IM_WRITE_EN
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_pc   (resp_pc),
    .resp_instr(resp_instr),
    .resp_err  (resp_err),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .func      (func),
    .imm       (imm),
    .ins25     (ins25)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic inRange(input logic [31:0] addr);
    return (addr >= BASE) && (addr < BASE + 32'd4096);
  endfunction

  function automatic resp_t expectedFor(input logic [31:0] addr);
    resp_t       r;
    logic [31:0] off;
    off     = addr - BASE;
    r.pc    = addr;
    r.err   = (addr[1:0] != 2'b00) || !inRange(addr);
    r.instr = r.err ? 32'h0 : model_mem[off[11:2]];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr);
    req_valid = valid;
    req_addr  = addr;
  endtask

  // Called 1 time unit after a negedge; scores this cycle, then waits for the next negedge
  task automatic step();
    resp_t       e;
    logic [31:0] ei;
    logic [31:0] off;
    if (!reset || flush) begin
      sb.delete();
    end else begin
      if (resp_valid && resp_ready) begin
        popCount++;
        if (sb.size() == 0) begin
          checkOutput("unexpected_resp", 32'd1, 32'd0);
        end else begin
          e  = sb.pop_front();
          ei = e.instr;
          checkOutput("resp_pc", resp_pc, e.pc);
          checkOutput("resp_instr", resp_instr, ei);
          checkOutput("resp_err", 32'(resp_err), 32'(e.err));
          checkOutput("op", 32'(op), 32'(ei[31:26]));
          checkOutput("rs", 32'(rs), 32'(ei[25:21]));
          checkOutput("rt", 32'(rt), 32'(ei[20:16]));
          checkOutput("rd", 32'(rd), 32'(ei[15:11]));
          checkOutput("func", 32'(func), 32'(ei[5:0]));
          checkOutput("imm", 32'(imm), 32'(ei[15:0]));
          checkOutput("ins25", 32'(ins25), 32'(ei[25:0]));
        end
      end
      if (req_valid && req_ready) begin
        acceptCount++;
        sb.push_back(expectedFor(req_addr));
      end
    end
`ifdef IM_WRITE_EN
    if (wr_en && wr_addr[1:0] == 2'b00 && inRange(wr_addr)) begin
      off = wr_addr - BASE;
      model_mem[off[11:2]] = wr_data;
    end
`else
    off = '0;
`endif
    @(negedge clk);
  endtask

  task automatic cycle();
    #1;
    step();
  endtask

  task automatic drain(input string tag);
    applyStimulus(1'b0, 32'h0);
    resp_ready = 1'b1;
    for (int n = 0; n < 40 && (sb.size() != 0 || resp_valid); n++) cycle();
    checkOutput(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int startAcc;
    int startPop;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = (i == 0) ? 32'h3C01_1234 : ((32'(i) * 32'h9E37_79B1) ^ 32'h0123_4567);
      dut.mem[i]   = model_mem[i];
    end

    // Reset values
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_pc", resp_pc, 32'h0);
    checkOutput("rst_resp_instr", resp_instr, 32'h0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_op", 32'(op), 32'd0);
    checkOutput("rst_ins25", 32'(ins25), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Single fetch latency and decode of word 0
    resp_ready = 1'b1;
    applyStimulus(1'b1, 32'h3000);
    cycle();
    applyStimulus(1'b0, 32'h0);
    #1;
    checkOutput("lat_edge1_valid", 32'(resp_valid), 32'd0);
    step();
    #1;
    checkOutput("lat_edge2_valid", 32'(resp_valid), 32'd1);
    checkOutput("w0_instr", resp_instr, 32'h3C01_1234);
    checkOutput("w0_op", 32'(op), 32'h0F);
    checkOutput("w0_rt", 32'(rt), 32'd1);
    checkOutput("w0_imm", 32'(imm), 32'h1234);
    checkOutput("w0_err", 32'(resp_err), 32'd0);
    step();
    #1;
    checkOutput("hold_valid", 32'(resp_valid), 32'd0);
    checkOutput("hold_instr", resp_instr, 32'h3C01_1234);
    checkOutput("hold_pc", resp_pc, 32'h3000);
    step();

    // Back-to-back stream at full rate
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i < 3, 32'h3000 + 32'(4 * i));
      #1;
      if (i < 3) checkOutput("b2b_req_ready", 32'(req_ready), 32'd1);
      if (i >= 2) checkOutput("b2b_resp_valid", 32'(resp_valid), 32'd1);
      step();
    end
    drain("b2b_drain");

    // Backpressure: stream with resp_ready low, then release
    resp_ready = 1'b0;
    startAcc = acceptCount;
    startPop = popCount;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'h3010 + 32'(4 * (acceptCount - startAcc)));
      cycle();
    end
    checkOutput("bp_accepts", 32'(acceptCount - startAcc), 32'd2);
    #1;
    checkOutput("bp_req_ready_low", 32'(req_ready), 32'd0);
    checkOutput("bp_resp_valid", 32'(resp_valid), 32'd1);
    applyStimulus(1'b0, 32'h0);
    resp_ready = 1'b1;
    #1;
    checkOutput("bp_comb_ready", 32'(req_ready), 32'd1);
    step();
    drain("bp_drain");
    checkOutput("bp_pops", 32'(popCount - startPop), 32'd2);

    // Error fetches plus the last valid word
    resp_ready = 1'b1;
    applyStimulus(1'b1, 32'h3002); cycle();
    applyStimulus(1'b1, 32'h2FFC); cycle();
    applyStimulus(1'b1, 32'h4000); cycle();
    applyStimulus(1'b1, 32'h3FFC); cycle();
    drain("err_drain");

    // Flush with one buffered and one in s1; same-cycle request refused
    resp_ready = 1'b0;
    applyStimulus(1'b1, 32'h3000); cycle();
    applyStimulus(1'b1, 32'h3004); cycle();
    flush = 1'b1;
    applyStimulus(1'b1, 32'h3020);
    #1;
    checkOutput("flush_req_ready", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0;
    applyStimulus(1'b0, 32'h0);
    #1;
    checkOutput("flush_empty", 32'(resp_valid), 32'd0);
    step();
    #1;
    checkOutput("flush_s1_gone", 32'(resp_valid), 32'd0);
    step();
    resp_ready = 1'b1;
    applyStimulus(1'b1, 32'h3010); cycle();
    applyStimulus(1'b0, 32'h0); cycle();
    #1;
    checkOutput("post_flush_valid", 32'(resp_valid), 32'd1);
    checkOutput("post_flush_pc", resp_pc, 32'h3010);
    step();
    drain("flush_drain");

    // Asynchronous reset mid-operation
    resp_ready = 1'b0;
    applyStimulus(1'b1, 32'h3008); cycle();
    applyStimulus(1'b0, 32'h0); cycle();
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(resp_valid), 32'd0);
    checkOutput("arst_instr", resp_instr, 32'h0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

`ifdef IM_WRITE_EN
    // Read-before-write on the same word, then re-read; misaligned write ignored
    resp_ready = 1'b1;
    wr_en = 1'b1; wr_addr = 32'h3004; wr_data = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 32'h3004); cycle();
    wr_en = 1'b1; wr_addr = 32'h3009; wr_data = 32'h0;
    applyStimulus(1'b1, 32'h3004); cycle();
    wr_en = 1'b0;
    applyStimulus(1'b1, 32'h3008); cycle();
    drain("wr_drain");
`endif

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0: a = BASE + 32'(4 * $urandom_range(0, 1023)) + 32'd2;
        1: a = BASE + 32'd4096 + 32'(4 * $urandom_range(0, 15));
        2: a = BASE + 32'd4092;
        default: a = BASE + 32'(4 * $urandom_range(0, 1023));
      endcase
      applyStimulus($urandom_range(0, 1) == 1, a);
      cycle();
    end
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
